// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU between two requesters.
// Optional per-requester stall counters are enabled by defining ALU_ARB_STALL_CNT_EN.
module alu_arbiter #(
    parameter int DATA_W  = 32,
    parameter int CMD_W   = 4,
    parameter int MAX_CMD = 9
`ifdef ALU_ARB_STALL_CNT_EN
    ,
    parameter int CNT_W   = 16
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [CMD_W-1:0]  req0_cmd,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [CMD_W-1:0]  req1_cmd,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    output logic [CMD_W-1:0]  alu_cmd,
    input  logic [DATA_W-1:0] alu_result,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              busy,
    output logic [1:0]        dbg_state
`ifdef ALU_ARB_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt0,
    output logic [CNT_W-1:0]  stall_cnt1
`endif
);
    // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
    // reqN_ready is combinational and only ever high in IDLE for the granted requester.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [CMD_W-1:0] MAX_CMD_V = CMD_W'(MAX_CMD);

    state_t              r_state;
    state_t              w_next_state;
    logic                r_last_grant;
    logic                r_gnt_id;
    logic [DATA_W-1:0]   r_alu_in1;
    logic [DATA_W-1:0]   r_alu_in2;
    logic [CMD_W-1:0]    r_alu_cmd;
    logic [DATA_W-1:0]   r_rsp_data;
    logic                r_rsp_valid;
    logic                r_rsp_id;
    logic                r_rsp_err;
    logic                w_any_valid;
    logic                w_grant;
    logic                w_accept;
    logic                w_illegal;

    // On a tie the requester that did not win last time gets the slot.
    always_comb begin
        w_any_valid = req0_valid | req1_valid;
        w_grant     = req1_valid;
        if (req0_valid && req1_valid) begin
            w_grant = ~r_last_grant;
        end
        w_accept  = (r_state == S_IDLE) && w_any_valid;
        w_illegal = (r_alu_cmd > MAX_CMD_V);
    end

    assign req0_ready = w_accept && !w_grant;
    assign req1_ready = w_accept && w_grant;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_any_valid) w_next_state = S_EXEC;
            S_EXEC:  w_next_state = S_RESP;
            S_RESP:  if (rsp_ready) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
            r_gnt_id     <= 1'b0;
            r_alu_in1    <= '0;
            r_alu_in2    <= '0;
            r_alu_cmd    <= '0;
            r_rsp_data   <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_alu_cmd    <= w_grant ? req1_cmd : req0_cmd;
                r_alu_in1    <= w_grant ? req1_a   : req0_a;
                r_alu_in2    <= w_grant ? req1_b   : req0_b;
                r_gnt_id     <= w_grant;
                r_last_grant <= w_grant;
            end
            // The ALU has had a full cycle to settle on the registered operands.
            if (r_state == S_EXEC) begin
                r_rsp_data  <= w_illegal ? '0 : alu_result;
                r_rsp_err   <= w_illegal;
                r_rsp_id    <= r_gnt_id;
                r_rsp_valid <= 1'b1;
            end else if ((r_state == S_RESP) && rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

`ifdef ALU_ARB_STALL_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt0;
    logic [CNT_W-1:0] r_stall_cnt1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt0 <= '0;
            r_stall_cnt1 <= '0;
        end else begin
            if (req0_valid && !req0_ready && (r_stall_cnt0 != '1)) begin
                r_stall_cnt0 <= r_stall_cnt0 + CNT_W'(1);
            end
            if (req1_valid && !req1_ready && (r_stall_cnt1 != '1)) begin
                r_stall_cnt1 <= r_stall_cnt1 + CNT_W'(1);
            end
        end
    end

    assign stall_cnt0 = r_stall_cnt0;
    assign stall_cnt1 = r_stall_cnt1;
`else
    // Stall counting is compiled out in this build.
`endif

    assign alu_in1   = r_alu_in1;
    assign alu_in2   = r_alu_in2;
    assign alu_cmd   = r_alu_cmd;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;
    assign busy      = (r_state != S_IDLE);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: directed vectors, expected-response queue, decoupled monitor.
module tb_alu_arbiter;
    localparam int DATA_W = 32;
    localparam int CMD_W  = 4;
    localparam int EXP_W  = DATA_W + 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req0_valid = 1'b0, req1_valid = 1'b0;
    logic              req0_ready, req1_ready;
    logic [CMD_W-1:0]  req0_cmd = '0, req1_cmd = '0;
    logic [DATA_W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [DATA_W-1:0] alu_in1, alu_in2, alu_result, rsp_data;
    logic [CMD_W-1:0]  alu_cmd;
    logic              rsp_valid, rsp_id, rsp_err, busy;
    logic              rsp_ready = 1'b0;
    logic [1:0]        dbg_state;

    logic [EXP_W-1:0]  exp_q[$];
    logic [EXP_W-1:0]  mon_exp;
    int                n_vec = 0;
    int                n_err = 0;
    int                cyc = 0;
    int                acc_cyc;

    // Directed table: {id, err, data} expected for each op.
    bit               t_req[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [3:0]       t_cmd[6] = '{4'd1, 4'd4, 4'd6, 4'd7, 4'd9, 4'd10};
    logic [31:0]      t_a[6]   = '{32'h0, 32'h0F0F0F0F, 32'h1, 32'h3, 32'h80000000, 32'h1};
    logic [31:0]      t_b[6]   = '{32'h1, 32'hF0F0F0F0, 32'd31, 32'd2, 32'd4, 32'h1};
    logic [EXP_W-1:0] t_exp[6] = '{{2'b10, 32'hFFFFFFFF}, {2'b00, 32'h0}, {2'b00, 32'h80000000},
                                   {2'b10, 32'h0000000C}, {2'b00, 32'hF8000000}, {2'b01, 32'h0}};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // External ALU model; illegal commands return a non-zero pattern so forcing to 0 is visible.
    always_comb begin
        case (alu_cmd)
            4'd0:    alu_result = alu_in1 + alu_in2;
            4'd1:    alu_result = alu_in1 - alu_in2;
            4'd2:    alu_result = alu_in1 & alu_in2;
            4'd3:    alu_result = alu_in1 | alu_in2;
            4'd4:    alu_result = ~(alu_in1 | alu_in2);
            4'd5:    alu_result = alu_in1 ^ alu_in2;
            4'd6:    alu_result = alu_in1 << alu_in2[4:0];
            4'd7:    alu_result = alu_in1 << alu_in2[4:0];
            4'd8:    alu_result = alu_in1 >> alu_in2[4:0];
            4'd9:    alu_result = $signed(alu_in1) >>> alu_in2[4:0];
            default: alu_result = 32'hDEADBEEF;
        endcase
    end

`ifdef ALU_ARB_STALL_CNT_EN
    logic [15:0] stall_cnt0, stall_cnt1;
    logic [15:0] m_stall0 = '0, m_stall1 = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            m_stall0 = '0;
            m_stall1 = '0;
        end else begin
            if (req0_valid && !req0_ready && m_stall0 != 16'hFFFF) m_stall0 = m_stall0 + 16'd1;
            if (req1_valid && !req1_ready && m_stall1 != 16'hFFFF) m_stall1 = m_stall1 + 16'd1;
        end
    end
`endif

    alu_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_cmd(req0_cmd),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_cmd(req1_cmd),
        .req1_a(req1_a), .req1_b(req1_b),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_cmd(alu_cmd), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy), .dbg_state(dbg_state)
`ifdef ALU_ARB_STALL_CNT_EN
        , .stall_cnt0(stall_cnt0), .stall_cnt1(stall_cnt1)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every completed response handshake is matched against the queue head.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 64'd1, 64'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("rsp", 64'({rsp_id, rsp_err, rsp_data}), 64'(mon_exp));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic issue(input bit req, input logic [3:0] cmd, input logic [31:0] a,
                         input logic [31:0] b, input bit push, input logic [EXP_W-1:0] exp,
                         output int acc);
        int t;
        t = 0;
        if (req) begin
            req1_valid = 1'b1; req1_cmd = cmd; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_cmd = cmd; req0_a = a; req0_b = b;
        end
        @(negedge clk);
        while (!(req ? req1_ready : req0_ready) && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("grant_timeout", 64'(t < 50), 64'd1);
        acc = cyc;
        if (push) exp_q.push_back(exp);
        @(posedge clk);
        #1;
        if (req) req1_valid = 1'b0;
        else     req0_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while ((busy || rsp_valid) && t < 50);
        check("idle_timeout", 64'(t < 50), 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int g;
        int t;
        // Reset state
        #12;
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_regs", 64'({alu_in1, alu_cmd, rsp_err, rsp_id}), 64'd0);
        check("rst_rsp_data", 64'(rsp_data), 64'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Tie from reset: req0 first, then alternate while both stay valid
        rsp_ready  = 1'b1;
        req0_valid = 1'b1; req0_cmd = 4'd1; req0_a = 32'h9;  req0_b = 32'h4;
        req1_valid = 1'b1; req1_cmd = 4'd5; req1_a = 32'hF0; req1_b = 32'h0F;
        g = 0;
        t = 0;
        while (g < 4 && t < 60) begin
            @(negedge clk);
            t++;
            if (req0_ready || req1_ready) begin
                check("tie_order", 64'(req1_ready), 64'(g % 2));
                exp_q.push_back(req1_ready ? {2'b10, 32'hFF} : {2'b00, 32'h5});
                g++;
            end
        end
        check("tie_grants", 64'(g), 64'd4);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_idle();

        // Single op with latency check
        issue(1'b0, 4'd0, 32'd5, 32'd7, 1'b1, {2'b00, 32'd12}, acc_cyc);
        t = 0;
        while (!rsp_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("latency", 64'(cyc - acc_cyc), 64'd2);
        check("alu_regs", 64'({alu_cmd, alu_in1[7:0], alu_in2[7:0]}), 64'h00507);
        wait_idle();

        // Backpressure: response held 5 cycles while req0 waits
        rsp_ready = 1'b0;
        issue(1'b1, 4'd2, 32'hFF00, 32'h0FF0, 1'b1, {2'b10, 32'h0F00}, acc_cyc);
        req0_valid = 1'b1; req0_cmd = 4'd3; req0_a = 32'h0A; req0_b = 32'h05;
        t = 0;
        while (!rsp_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        for (int i = 0; i < 5; i++) begin
            check("bp_data", 64'({rsp_id, rsp_err, rsp_data}), 64'({2'b10, 32'h0F00}));
            check("bp_ready", 64'({req0_ready, req1_ready}), 64'd0);
            check("bp_busy", 64'(busy), 64'd1);
            @(negedge clk);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("idle_after_accept", 64'({busy, req0_ready}), 64'b01);
        exp_q.push_back({2'b00, 32'h0F});
        @(posedge clk);
        #1 req0_valid = 1'b0;
        wait_idle();

        // Illegal command from req1
        issue(1'b1, 4'hC, 32'd3, 32'd3, 1'b1, {2'b11, 32'h0}, acc_cyc);
        wait_idle();

        // Directed table, including the MAX_CMD boundary and one past it
        for (int i = 0; i < 6; i++) begin
            issue(t_req[i], t_cmd[i], t_a[i], t_b[i], 1'b1, t_exp[i], acc_cyc);
            wait_idle();
        end

        // Reset while in EXEC: op is dropped, no response ever appears
        issue(1'b0, 4'd0, 32'd1, 32'd1, 1'b0, '0, acc_cyc);
        #2 rst_n = 1'b0;
        #1;
        check("rst_exec_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_exec_busy", 64'(busy), 64'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("no_rsp_after_rst", 64'({rsp_valid, busy}), 64'd0);
        @(posedge clk);
        #1;
        issue(1'b0, 4'd8, 32'h80, 32'd3, 1'b1, {2'b00, 32'h10}, acc_cyc);
        wait_idle();

`ifdef ALU_ARB_STALL_CNT_EN
        req0_valid = 1'b1; req0_cmd = 4'd0; req0_a = 32'd1; req0_b = 32'd1;
        req1_valid = 1'b1; req1_cmd = 4'd0; req1_a = 32'd2; req1_b = 32'd2;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (req0_ready) exp_q.push_back({2'b00, 32'd2});
            if (req1_ready) exp_q.push_back({2'b10, 32'd4});
        end
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_idle();
        check("stall_cnt0", 64'(stall_cnt0), 64'(m_stall0));
        check("stall_cnt1", 64'(stall_cnt1), 64'(m_stall1));
`endif

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
